// File: rtl/alu_issue_wb.sv
// alu_issue_wb: two-state issue/writeback sequencer around an external
// combinational ALU, with an 8 x 8-bit register file, a side load port and
// a combinational debug read port.
module alu_issue_wb #(
    parameter bit R0_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_sel,
    output logic [2:0]  alu_shift,
    input  logic [7:0]  alu_out,
    input  logic        alu_carry,
    input  logic        alu_overflow,
    input  logic        ld_en,
    input  logic [2:0]  ld_addr,
    input  logic [7:0]  ld_data,
    input  logic [2:0]  dbg_addr,
    output logic [7:0]  dbg_data,
    output logic [7:0]  result,
    output logic [3:0]  status,
    output logic        done,
    output logic        div0_err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EXEC = 1'b1;

    logic [0:0] state;
    logic [2:0] rd_q;
    logic [7:0] rf [8];

    logic wb_div0;
    logic wb_wr;
    logic ld_wr;
    logic add_sub;

    // Register read with r0 hardwired to zero when enabled.
    function automatic logic [7:0] rf_read(input logic [2:0] a);
        if (R0_ZERO && (a == 3'd0)) return 8'h00;
        return rf[a];
    endfunction

    // Ready only in IDLE and never while reset is held.
    assign instr_ready = (state == S_IDLE) && !rst;

    assign dbg_data = rf_read(dbg_addr);

    // Only add/sub report carry and overflow; every other op clears them.
    assign add_sub = (alu_sel[3:1] == 3'b000);

    // Divide by zero suppresses the register, result and status update.
    assign wb_div0 = (state == S_EXEC) && (alu_sel == 4'b0011) && (alu_b == 8'h00);

    // Writeback to r0 is dropped when r0 is hardwired.
    assign wb_wr = (state == S_EXEC) && !wb_div0 && !(R0_ZERO && (rd_q == 3'd0));

    // Side load loses to a same-edge writeback of the same register.
    assign ld_wr = ld_en && !(R0_ZERO && (ld_addr == 3'd0)) &&
                   !(wb_wr && (ld_addr == rd_q));

    // Issue/writeback sequencer, register file and retired-result state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rd_q      <= 3'd0;
            alu_a     <= 8'h00;
            alu_b     <= 8'h00;
            alu_sel   <= 4'h0;
            alu_shift <= 3'd0;
            result    <= 8'h00;
            status    <= 4'h0;
            done      <= 1'b0;
            div0_err  <= 1'b0;
            for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
        end else begin
            done <= 1'b0;
            if (ld_wr) rf[ld_addr] <= ld_data;
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        alu_sel   <= instr[15:12];
                        rd_q      <= instr[11:9];
                        alu_a     <= rf_read(instr[8:6]);
                        alu_b     <= rf_read(instr[5:3]);
                        alu_shift <= instr[2:0];
                        state     <= S_EXEC;
                    end
                end
                default: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                    if (wb_div0) begin
                        div0_err <= 1'b1;
                    end else begin
                        if (wb_wr) rf[rd_q] <= alu_out;
                        result <= alu_out;
                        status <= {(alu_out == 8'h00), alu_out[7],
                                   add_sub & alu_carry, add_sub & alu_overflow};
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_wb.sv
// Scoreboarded bench for alu_issue_wb: a behavioural ALU drives the DUT's ALU
// port, a reference register-file model predicts each retirement, and a
// monitor compares every done pulse against the queued expectation.
module tb_alu_issue_wb;

    localparam bit R0Z = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_sel;
    logic [2:0]  alu_shift;
    logic [7:0]  alu_out;
    logic        alu_carry, alu_overflow;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [7:0]  ld_data;
    logic [2:0]  dbg_addr;
    logic [7:0]  dbg_data;
    logic [7:0]  result;
    logic [3:0]  status;
    logic        done;
    logic        div0_err;

    alu_issue_wb #(.R0_ZERO(R0Z)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_shift(alu_shift), .alu_out(alu_out), .alu_carry(alu_carry),
        .alu_overflow(alu_overflow), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .result(result), .status(status), .done(done), .div0_err(div0_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural ALU: returns {carry, overflow, out}. Non add/sub ops return
    // junk carry/overflow so the DUT's clearing of C/V is exercised.
    function automatic logic [9:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [2:0] sh);
        int s;
        logic [7:0] o;
        logic c, v;
        case (op)
            4'd0: begin s = int'(a) + int'(b); o = 8'(s); c = (s > 255);
                        v = (a[7] == b[7]) && (o[7] != a[7]); end
            4'd1: begin o = a - b; c = (a < b);
                        v = (a[7] != b[7]) && (o[7] != a[7]); end
            4'd2: begin o = 8'(int'(a) * int'(b)); c = o[0]; v = o[1]; end
            4'd3: begin o = (b == 8'h00) ? 8'hFF : a / b; c = 1'b1; v = 1'b1; end
            4'd4: begin o = a << sh; c = 1'b1; v = 1'b0; end
            4'd5: begin o = a >> sh; c = 1'b0; v = 1'b1; end
            4'd8: begin o = a & b; c = 1'b1; v = 1'b1; end
            4'd9: begin o = a | b; c = o[0]; v = o[1]; end
            4'd10: begin o = a ^ b; c = o[2]; v = o[3]; end
            default: begin o = ~a; c = 1'b1; v = 1'b1; end
        endcase
        return {c, v, o};
    endfunction

    logic [9:0] alu_res;
    always_comb begin
        alu_res      = alu_f(alu_sel, alu_a, alu_b, alu_shift);
        alu_out      = alu_res[7:0];
        alu_overflow = alu_res[8];
        alu_carry    = alu_res[9];
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct packed {
        logic [7:0] res;
        logic [3:0] st;
        logic       d0;
    } exp_t;

    exp_t       q[$];
    logic [7:0] m_rf [8];
    logic [7:0] m_res;
    logic [3:0] m_st;
    logic       m_d0;

    function automatic logic [7:0] mrd(input logic [2:0] a);
        return (R0Z && a == 3'd0) ? 8'h00 : m_rf[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
        m_res = 8'h00; m_st = 4'h0; m_d0 = 1'b0;
    endtask

    task automatic model_ld(input logic [2:0] a, input logic [7:0] d);
        if (!(R0Z && a == 3'd0)) m_rf[a] = d;
    endtask

    // Predict one instruction's retirement and queue it for the monitor.
    task automatic model_issue(input logic [15:0] ins, output logic [7:0] ea,
                               output logic [7:0] eb);
        logic [3:0] op;
        logic [2:0] rd;
        logic [9:0] r;
        exp_t e;
        op = ins[15:12]; rd = ins[11:9];
        ea = mrd(ins[8:6]); eb = mrd(ins[5:3]);
        r  = alu_f(op, ea, eb, ins[2:0]);
        if (op == 4'd3 && eb == 8'h00) begin
            m_d0 = 1'b1;
        end else begin
            if (!(R0Z && rd == 3'd0)) m_rf[rd] = r[7:0];
            m_res = r[7:0];
            m_st  = {(r[7:0] == 8'h00), r[7], (op <= 4'd1) ? r[9] : 1'b0,
                     (op <= 4'd1) ? r[8] : 1'b0};
        end
        e.res = m_res; e.st = m_st; e.d0 = m_d0;
        q.push_back(e);
    endtask

    // Monitor: every done pulse retires exactly one queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("wb_result", 32'(result), 32'(e.res));
                    chk("wb_status", 32'(status), 32'(e.st));
                    chk("wb_div0_err", 32'(div0_err), 32'(e.d0));
                end
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    function automatic logic [15:0] mk(input int op, input int rd, input int rs1,
                                       input int rs2, input int sh);
        return {4'(op), 3'(rd), 3'(rs1), 3'(rs2), 3'(sh)};
    endfunction

    task automatic do_ld(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk);
        #1 ld_en = 1'b0;
        model_ld(a, d);
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        @(negedge clk);
        while (instr_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (instr_ready !== 1'b1) chk("ready_timeout", 32'(instr_ready), 32'd1);
    endtask

    // Issue one instruction; returns at the writeback edge. An optional side
    // load is placed on the writeback edge.
    task automatic issue(input logic [15:0] ins, input bit with_ld,
                         input logic [2:0] la, input logic [7:0] ldat);
        logic [7:0] ea, eb;
        wait_ready();
        instr_valid = 1'b1; instr = ins;
        @(posedge clk);
        model_issue(ins, ea, eb);
        #1;
        instr_valid = 1'b0;
        chk("issue_alu_a", 32'(alu_a), 32'(ea));
        chk("issue_alu_b", 32'(alu_b), 32'(eb));
        chk("issue_alu_sel", 32'(alu_sel), 32'(ins[15:12]));
        chk("issue_alu_shift", 32'(alu_shift), 32'(ins[2:0]));
        if (with_ld) begin
            @(negedge clk);
            ld_en = 1'b1; ld_addr = la; ld_data = ldat;
        end
        @(posedge clk);
        if (with_ld) begin
            #1 ld_en = 1'b0;
            if (la != ins[11:9]) model_ld(la, ldat);
        end
    endtask

    task automatic sweep(input string tag);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            chk(tag, 32'(dbg_data), 32'(m_rf[i] & ((R0Z && i == 0) ? 8'h00 : 8'hFF)));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] ea, eb;
        rst = 1'b1; instr_valid = 1'b0; instr = 16'h0;
        ld_en = 1'b0; ld_addr = 3'd0; ld_data = 8'h00; dbg_addr = 3'd0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_div0", 32'(div0_err), 32'd0);
        chk("rst_alu_ab", 32'({alu_a, alu_b, alu_sel, alu_shift}), 32'd0);
        rst = 1'b0;
        #1 chk("ready_after_rst", 32'(instr_ready), 32'd1);
        sweep("rst_reg");

        // add overflow case
        do_ld(3'd1, 8'h7F);
        do_ld(3'd2, 8'h01);
        issue(mk(0, 3, 1, 2, 0), 1'b0, 3'd0, 8'h00);
        @(negedge clk);
        chk("add_done", 32'(done), 32'd1);
        chk("add_result", 32'(result), 32'h80);
        chk("add_status", 32'(status), 32'b0101);
        sweep("add_reg");

        // divide by zero, sticky across later instructions
        do_ld(3'd4, 8'h00);
        issue(mk(3, 5, 1, 4, 0), 1'b0, 3'd0, 8'h00);
        @(negedge clk);
        chk("div0_flag", 32'(div0_err), 32'd1);
        chk("div0_status_kept", 32'(status), 32'b0101);
        issue(mk(9, 6, 1, 2, 0), 1'b0, 3'd0, 8'h00);
        @(negedge clk);
        chk("div0_sticky", 32'(div0_err), 32'd1);

        // write to r0 is discarded but status/result update
        issue(mk(8, 0, 1, 1, 0), 1'b0, 3'd0, 8'h00);
        @(negedge clk);
        chk("r0_result", 32'(result), 32'h7F);
        sweep("r0_reg");

        // back-to-back with instr_valid held high
        @(negedge clk);
        instr_valid = 1'b1; instr = mk(0, 4, 1, 2, 0);
        chk("b2b_ready_1", 32'(instr_ready), 32'd1);
        @(posedge clk);
        model_issue(instr, ea, eb);
        @(negedge clk);
        chk("b2b_ready_0", 32'(instr_ready), 32'd0);
        instr = mk(0, 5, 4, 4, 0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_ready_1b", 32'(instr_ready), 32'd1);
        @(posedge clk);
        model_issue(instr, ea, eb);
        #1 chk("b2b_fwd_a", 32'(alu_a), 32'h80);
        @(negedge clk);
        chk("b2b_ready_0b", 32'(instr_ready), 32'd0);
        instr_valid = 1'b0;
        @(posedge clk);
        sweep("b2b_reg");

        // side load colliding with writeback: same address vs different address
        issue(mk(0, 3, 1, 1, 0), 1'b1, 3'd3, 8'hAA);
        sweep("ld_same_reg");
        issue(mk(1, 3, 2, 1, 0), 1'b1, 3'd6, 8'h5C);
        sweep("ld_diff_reg");

        // randomized traffic
        for (int n = 0; n < 160; n++) begin
            if ($urandom_range(0, 3) == 0)
                do_ld(3'($urandom_range(0, 7)), 8'($urandom));
            else
                issue(16'($urandom), 1'b0, 3'd0, 8'h00);
            if (n % 20 == 19) sweep("rand_reg");
        end

        // reset during EXEC aborts the instruction
        wait_ready();
        instr_valid = 1'b1; instr = mk(0, 7, 1, 2, 0);
        @(posedge clk);
        model_issue(instr, ea, eb);
        @(negedge clk);
        instr_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_ready_in_rst", 32'(instr_ready), 32'd0);
        void'(q.pop_back());
        model_reset();
        rst = 1'b0;
        #1 chk("abort_ready_after", 32'(instr_ready), 32'd1);
        chk("abort_status", 32'(status), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_div0", 32'(div0_err), 32'd0);
        sweep("abort_reg");

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
